// File: rtl/adc_rx_mchan.sv
// Multi-channel ADC receive front end: capture, DC offset removal with saturation,
// optional 2^DEC_LOG2 average/decimate, enable/settle gating, overrange statistics.
// Define ADC_OFFSET_BIN_EN when adc_d arrives as offset-binary.
module adc_rx_mchan #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DW       = 14,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned DEC_LOG2 = 0,
  parameter int unsigned OR_CNT_W = 16
) (
  input  logic                    adc_clk100m,
  input  logic                    ad_rst_n,
  input  logic                    rx_en,
  input  logic [DW-1:0]           sub_value,
  input  logic [NCH*DW-1:0]       adc_d,
  input  logic [NCH-1:0]          adc_or,
  input  logic                    or_clr,
  output logic [NCH*DW-1:0]       ad_data,
  output logic                    ad_data_valid,
  output logic [NCH-1:0]          or_flag,
  output logic [NCH*OR_CNT_W-1:0] or_count,
  output logic [1:0]              rx_state
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic               settle_done;
  logic               run_nxt;
  logic [NCH*DW-1:0]  d_in_c;
  logic [NCH*DW-1:0]  s1_d;
  logic [NCH-1:0]     s1_or;
  logic [NCH*DW-1:0]  diff_c;
  logic [NCH*DW-1:0]  s2_d;

  // Subtract in DW+1 bits and clamp back into the signed DW range.
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    if (d[DW] != d[DW-1])
      sat_sub = d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_sub = d[DW-1:0];
  endfunction

  assign settle_done = (settle_cnt == CNT_W'(SETTLE - 1));
  // High when the state register will hold RUN after this edge.
  assign run_nxt     = rx_en && ((state == S_RUN) || ((state == S_SETTLE) && settle_done));
  assign rx_state    = state;

  always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
    if (!ad_rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else if (!rx_en) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_SETTLE;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          if (settle_done) state <= S_RUN;
          else             settle_cnt <= settle_cnt + CNT_W'(1);
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    d_in_c = adc_d;
`ifdef ADC_OFFSET_BIN_EN
    for (int k = 0; k < NCH; k++) d_in_c[k*DW + DW - 1] = ~adc_d[k*DW + DW - 1];
`endif
  end

  always_comb begin
    diff_c = '0;
    for (int k = 0; k < NCH; k++) diff_c[k*DW +: DW] = sat_sub(s1_d[k*DW +: DW], sub_value);
  end

  always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
    if (!ad_rst_n) begin
      s1_d  <= '0;
      s1_or <= '0;
      s2_d  <= '0;
    end else begin
      s1_d  <= d_in_c;
      s1_or <= adc_or;
      s2_d  <= diff_c;
    end
  end

  generate
    if (DEC_LOG2 == 0) begin : g_pass
      always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
        if (!ad_rst_n) begin
          ad_data       <= '0;
          ad_data_valid <= 1'b0;
        end else begin
          ad_data       <= s2_d;
          ad_data_valid <= run_nxt;
        end
      end
    end else begin : g_dec
      localparam int unsigned AW = DW + DEC_LOG2;
      localparam int unsigned PW = DEC_LOG2;

      logic [NCH*AW-1:0] acc;
      logic [NCH*AW-1:0] sum_c;
      logic [NCH*DW-1:0] avg_c;
      logic [PW-1:0]     phase;
      logic              v1;
      logic              v2;

      always_comb begin
        sum_c = '0;
        avg_c = '0;
        for (int k = 0; k < NCH; k++) begin
          sum_c[k*AW +: AW] = acc[k*AW +: AW] + AW'($signed(s2_d[k*DW +: DW]));
          avg_c[k*DW +: DW] = DW'($signed(sum_c[k*AW +: AW]) >>> DEC_LOG2);
        end
      end

      // v1/v2 tag stage-1/stage-2 samples that were captured while running.
      always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
        if (!ad_rst_n) begin
          acc           <= '0;
          phase         <= '0;
          v1            <= 1'b0;
          v2            <= 1'b0;
          ad_data       <= '0;
          ad_data_valid <= 1'b0;
        end else begin
          v1            <= run_nxt && (state == S_RUN);
          v2            <= run_nxt && v1;
          ad_data_valid <= 1'b0;
          if (!run_nxt) begin
            acc   <= '0;
            phase <= '0;
          end else if (v2) begin
            phase <= phase + PW'(1);
            if (&phase) begin
              acc           <= '0;
              ad_data       <= avg_c;
              ad_data_valid <= 1'b1;
            end else begin
              acc <= sum_c;
            end
          end
        end
      end
    end
  endgenerate

  // Overrange statistics run in every state; a clear wins over a same-cycle event.
  always_ff @(posedge adc_clk100m or negedge ad_rst_n) begin
    if (!ad_rst_n) begin
      or_flag  <= '0;
      or_count <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (or_clr) begin
          or_flag[k]                      <= 1'b0;
          or_count[k*OR_CNT_W +: OR_CNT_W] <= '0;
        end else if (s1_or[k]) begin
          or_flag[k] <= 1'b1;
          if (!(&or_count[k*OR_CNT_W +: OR_CNT_W]))
            or_count[k*OR_CNT_W +: OR_CNT_W] <= or_count[k*OR_CNT_W +: OR_CNT_W] + OR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_rx_mchan.sv
// Bench for adc_rx_mchan: a pass-through and a decimate-by-4 instance share stimulus
// and are checked every cycle against a sample-history model plus literal expectations.
`timescale 1ns/1ps
module tb_adc_rx_mchan;

  localparam int NCH  = 2;
  localparam int DW   = 14;
  localparam int ORW  = 4;
  localparam int SET  = 16;
  localparam int MAXC = 4000;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               rx_en = 1'b0;
  logic               or_clr = 1'b0;
  logic [DW-1:0]      sub_value = '0;
  logic [NCH*DW-1:0]  adc_d = '0;
  logic [NCH-1:0]     adc_or = '0;

  logic [NCH*DW-1:0]  a_data, b_data;
  logic               a_valid, b_valid;
  logic [NCH-1:0]     a_orf, b_orf;
  logic [NCH*ORW-1:0] a_orc, b_orc;
  logic [1:0]         a_state, b_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  adc_rx_mchan #(.NCH(NCH), .DW(DW), .SETTLE(SET), .DEC_LOG2(0), .OR_CNT_W(ORW)) u_pass (
    .adc_clk100m(clk), .ad_rst_n(rst_n), .rx_en(rx_en), .sub_value(sub_value),
    .adc_d(adc_d), .adc_or(adc_or), .or_clr(or_clr), .ad_data(a_data),
    .ad_data_valid(a_valid), .or_flag(a_orf), .or_count(a_orc), .rx_state(a_state));

  adc_rx_mchan #(.NCH(NCH), .DW(DW), .SETTLE(SET), .DEC_LOG2(2), .OR_CNT_W(ORW)) u_dec (
    .adc_clk100m(clk), .ad_rst_n(rst_n), .rx_en(rx_en), .sub_value(sub_value),
    .adc_d(adc_d), .adc_or(adc_or), .or_clr(or_clr), .ad_data(b_data),
    .ad_data_valid(b_valid), .or_flag(b_orf), .or_count(b_orc), .rx_state(b_state));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int a, input int b);
    int d;
    d = a - b;
    if (d > MAXV) d = MAXV;
    else if (d < MINV) d = MINV;
    return d;
  endfunction

  function automatic int get(input logic [NCH*DW-1:0] v, input int k);
    logic [DW-1:0] s;
    s = v[k*DW +: DW];
    return int'($signed(s));
  endfunction

  // Pin value back to a two's complement sample.
  function automatic int dec(input logic [DW-1:0] raw);
    logic [DW-1:0] r;
    r = raw;
`ifdef ADC_OFFSET_BIN_EN
    r[DW-1] = ~r[DW-1];
`endif
    return int'($signed(r));
  endfunction

  function automatic logic [DW-1:0] enc(input int v);
    logic [DW-1:0] r;
    r = DW'(v);
`ifdef ADC_OFFSET_BIN_EN
    r[DW-1] = ~r[DW-1];
`endif
    return r;
  endfunction

  task automatic set_d(input int v0, input int v1);
    adc_d = {enc(v1), enc(v0)};
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Input history, indexed by cycle, plus model state.
  int en_h  [MAXC];
  int sub_h [MAXC];
  int clr_h [MAXC];
  int st_h  [MAXC];
  int d_h   [MAXC][NCH];
  int or_h  [MAXC][NCH];
  int run_len = 0;
  int grp = 0;
  int gsum [NCH];
  int last [NCH];
  int ocnt [NCH];
  int oflg [NCH];

  always @(negedge clk) begin
    int t, es, ev;
    t = cyc;
    if (t >= 1 && t < MAXC) begin
      // State follows from how many cycles rx_en has been held high.
      run_len = (en_h[t-1] != 0) ? run_len + 1 : 0;
      es = (run_len == 0) ? 0 : ((run_len <= SET) ? 1 : 2);
      st_h[t] = es;
      chk("state_pass", int'(a_state), es);
      chk("state_dec", int'(b_state), es);
      chk("valid_pass", int'(a_valid), (es == 2) ? 1 : 0);
      if (es == 2 && t >= 3)
        for (int k = 0; k < NCH; k++)
          chk("data_pass", get(a_data, k), sat(d_h[t-3][k], sub_h[t-2]));

      // Average of each group of four run samples, counted from the start of a run.
      ev = 0;
      if (es != 2) begin
        grp = 0;
        for (int k = 0; k < NCH; k++) gsum[k] = 0;
      end else if (t >= 3 && st_h[t-3] == 2 && st_h[t-2] == 2 && st_h[t-1] == 2) begin
        grp++;
        for (int k = 0; k < NCH; k++) gsum[k] += sat(d_h[t-3][k], sub_h[t-2]);
        if (grp == 4) begin
          ev = 1;
          grp = 0;
          for (int k = 0; k < NCH; k++) begin
            last[k] = gsum[k] >>> 2;
            gsum[k] = 0;
          end
        end
      end
      chk("valid_dec", int'(b_valid), ev);
      for (int k = 0; k < NCH; k++) chk("data_dec", get(b_data, k), last[k]);

      if (t >= 2)
        for (int k = 0; k < NCH; k++) begin
          if (clr_h[t-1] != 0) begin
            ocnt[k] = 0;
            oflg[k] = 0;
          end else if (or_h[t-2][k] != 0) begin
            oflg[k] = 1;
            if (ocnt[k] < (1 << ORW) - 1) ocnt[k]++;
          end
        end
      for (int k = 0; k < NCH; k++) begin
        chk("orflag_pass", int'(a_orf[k]), oflg[k]);
        chk("orflag_dec", int'(b_orf[k]), oflg[k]);
        chk("orcnt_pass", int'(a_orc[k*ORW +: ORW]), ocnt[k]);
        chk("orcnt_dec", int'(b_orc[k*ORW +: ORW]), ocnt[k]);
      end

      en_h[t]  = int'(rx_en);
      sub_h[t] = int'($signed(sub_value));
      clr_h[t] = int'(or_clr);
      for (int k = 0; k < NCH; k++) begin
        d_h[t][k]  = dec(adc_d[k*DW +: DW]);
        or_h[t][k] = int'(adc_or[k]);
      end
    end
  end

  initial begin
    int pat0 [4];
    int patn [4];
    int run_at;
    int got;
    logic [DW-1:0] raw;
    pat0 = '{4, 5, 6, 8};
    patn = '{-1, -1, -1, -2};

    #1 rst_n = 1'b0;
    set_d(0, 0);
    tick(3);
    chk("rst_state", int'(a_state), 0);
    chk("rst_valid", int'(a_valid) + int'(b_valid), 0);
    chk("rst_data", get(a_data, 0), 0);
    chk("rst_orflag", int'(a_orf), 0);
    chk("rst_orcnt", int'(b_orc), 0);
    rst_n = 1'b1;
    tick(2);

    // Enable and ramp through settle into run.
    rx_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_d(i * 7, 100 - i * 3);
      tick(1);
      if (i == 0)  chk("settle_entry", int'(a_state), 1);
      if (i == 15) chk("settle_last", int'(a_state), 1);
      if (i == 16) chk("run_entry", int'(a_state), 2);
    end
    chk("run_valid", int'(a_valid), 1);

    // Saturation at both rails.
    sub_value = DW'(-8192);
    set_d(8191, 8191);
    tick(4);
    chk("sat_pos", get(a_data, 0), 8191);
    sub_value = DW'(1);
    set_d(-8192, -8192);
    tick(4);
    chk("sat_neg", get(a_data, 1), -8192);

    // Decimate-by-4 averages of repeating patterns.
    sub_value = '0;
    for (int i = 0; i < 16; i++) begin
      set_d(pat0[i % 4], -100 * (i % 4));
      tick(1);
    end
    chk("avg_pos", get(b_data, 0), 5);
    for (int i = 0; i < 16; i++) begin
      set_d(patn[i % 4], 7);
      tick(1);
    end
    chk("avg_neg", get(b_data, 0), -2);

    // Drop enable mid-accumulation with large samples in flight.
    set_d(1000, 1000);
    tick(2);
    rx_en = 1'b0;
    tick(1);
    chk("drop_valid", int'(a_valid) + int'(b_valid), 0);
    chk("drop_state", int'(b_state), 0);
    tick(3);

    // Re-enable: full settle again, first average uses only fresh samples.
    rx_en = 1'b1;
    run_at = -1;
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      set_d(pat0[i % 4], 0);
      tick(1);
      if (b_state == 2'd2 && run_at < 0) run_at = i;
      if (b_valid) begin
        got = 1;
        chk("first_pulse_data", get(b_data, 0), 5);
        chk("first_pulse_lat", i - run_at, 6);
      end
    end
    if (got == 0) chk("first_pulse_timeout", 0, 1);
    rx_en = 1'b0;
    tick(2);

    // Overrange counter saturation on channel 1 only.
    adc_or = 2'b10;
    tick(20);
    adc_or = 2'b00;
    tick(2);
    chk("or_cnt1_sat", int'(a_orc[ORW +: ORW]), 15);
    chk("or_cnt0", int'(a_orc[0 +: ORW]), 0);
    chk("or_flag", int'(a_orf), 2);

    // Clear arriving together with a captured overrange event.
    adc_or = 2'b10;
    tick(3);
    adc_or = 2'b00;
    or_clr = 1'b1;
    tick(1);
    or_clr = 1'b0;
    tick(2);
    chk("or_clr_cnt", int'(a_orc[ORW +: ORW]), 0);
    chk("or_clr_flag", int'(a_orf), 0);

    // Raw pin codes at mid-scale and full-scale.
    sub_value = '0;
    raw = 14'h2000;
    adc_d = {raw, raw};
    tick(4);
`ifdef ADC_OFFSET_BIN_EN
    chk("raw_mid", get(a_data, 0), 0);
`else
    chk("raw_mid", get(a_data, 0), -8192);
`endif
    raw = 14'h3FFF;
    adc_d = {raw, raw};
    tick(4);
`ifdef ADC_OFFSET_BIN_EN
    chk("raw_full", get(a_data, 1), 8191);
`else
    chk("raw_full", get(a_data, 1), -1);
`endif

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_rx_mchan.md
Name: adc_rx_mchan

Overview:
Parametrised multi-channel ADC receive front end, successor to the fixed dual-channel I/Q receive path.
- Registers NCH parallel ADC channels, subtracts a programmable DC offset with saturation, and optionally averages/decimates by 2^DEC_LOG2.
- Gates output through an enable/settle state machine and keeps per-channel overrange statistics.
- Sits between the ADC pins/capture and the demodulator; all channels share one sample clock.

Parameters:
- NCH, 2, number of ADC channels
- DW, 14, sample width per channel (bits)
- SETTLE, 16, samples discarded after rx_en rises (1..65535)
- DEC_LOG2, 0, log2 of average/decimate factor (0..4; 0 = pass-through)
- OR_CNT_W, 16, width of per-channel overrange counter

Ports:
- adc_clk100m  in  1  sample clock, all logic rising-edge
- ad_rst_n  in  1  asynchronous active-low reset
- rx_en  in  1  receive enable
- sub_value  in  DW  signed offset subtracted from every channel
- adc_d  in  NCH*DW  raw samples, channel k at [k*DW +: DW]
- adc_or  in  NCH  ADC overrange bits
- or_clr  in  1  clears or_flag and or_count (single-cycle pulse)
- ad_data  out  NCH*DW  signed processed samples, same packing as adc_d
- ad_data_valid  out  1  ad_data qualifier
- or_flag  out  NCH  sticky overrange flag per channel
- or_count  out  NCH*OR_CNT_W  overrange sample count per channel
- rx_state  out  2  FSM state: 0 IDLE, 1 SETTLE, 2 RUN

Behaviour:
- Reset: ad_data=0, ad_data_valid=0, or_flag=0, or_count=0, rx_state=IDLE; pipeline, accumulators and settle counter cleared. Reset mid-run aborts immediately; no partial output.
- Stage 1: adc_d and adc_or registered every cycle, independent of state.
- Stage 2: diff = sext(d) - sext(sub_value), computed in DW+1 bits.
  - Saturated to [-2^(DW-1), 2^(DW-1)-1].
  - sub_value is sampled every cycle; a change takes effect on the next sample.
- Stage 3, DEC_LOG2=0: registered result, ad_data_valid=1 every RUN cycle. Latency from adc_d to ad_data is 3 cycles.
- Stage 3, DEC_LOG2=K>0:
  - Per-channel accumulator of DW+K bits sums 2^K consecutive saturated samples.
  - Output = sum >>> K (arithmetic, floor).
  - ad_data_valid is a one-cycle pulse every 2^K RUN samples; the first pulse comes 2^K+2 cycles after entry to RUN.
  - ad_data holds its value between pulses.
- FSM:
  - IDLE --rx_en=1--> SETTLE: counter loads 0.
  - SETTLE: counter increments each cycle; at count SETTLE-1 go to RUN; accumulators zeroed on entry to RUN.
  - RUN: stays while rx_en=1.
  - rx_en=0 in any state → IDLE next cycle. ad_data_valid is forced 0 from that cycle onward, and accumulators/decimation phase are cleared.
  - No valid output while in IDLE or SETTLE.
- Overrange (per channel, uses stage-1 adc_or, counted in all states):
  - or_count increments when OR=1 and saturates at 2^OR_CNT_W-1, with no wrap.
  - or_flag sets on any OR=1 and stays set until cleared.
  - or_clr has priority: on a cycle with both or_clr and OR=1, flag=0 and count=0, and that event is dropped.

Optional Feature:
- Macro ADC_OFFSET_BIN_EN.
- Defined: adc_d is offset-binary; the MSB of each channel is inverted in stage 1 (before subtraction) to give two's complement.
- Undefined: adc_d is taken as two's complement unchanged.
- Latency and all other behaviour are identical in both cases.

Test Plan:
- Case 1, NCH=2, DW=14, DEC_LOG2=0, SETTLE=16, sub_value=0: raise rx_en, drive ramp. Required response:
  - rx_state goes 1 then 2 after 16 cycles.
  - Thereafter ad_data equals adc_d delayed 3 cycles, with valid held high.
- Saturation, sub_value=14'sh2000 (-8192), adc_d=14'sh1FFF: ad_data=14'sh1FFF, not wrapped. With sub_value=1 and adc_d=14'sh2000: ad_data=14'sh2000.
- DEC_LOG2=2, channel 0 samples 4,5,6,8 repeating: valid pulses every 4 cycles with ad_data=5 (23>>>2). Samples -1,-1,-1,-2 give -2.
- rx_en dropped in RUN mid-accumulation:
  - valid=0 on the next cycle and rx_state=0.
  - Re-enabling repeats the full SETTLE and the first output excludes stale samples.
- OR stimulus, OR_CNT_W=4:
  - adc_or[1] high 20 cycles: or_count[1]=15 (saturated), or_flag=2'b10, channel 0 count 0.
  - or_clr coincident with OR=1: count=0 and flag=0.
- ADC_OFFSET_BIN_EN defined, adc_d=14'h2000, sub_value=0: ad_data=0. adc_d=14'h3FFF gives 14'sh1FFF.
